// File: rtl/ifetch_pkg.sv
// Shared constants and the fetch-buffer entry type for the instruction fetch unit.
package ifetch_pkg;
   localparam int          ADDR_W   = 32;
   localparam int          INSTR_W  = 32;
   localparam logic [31:0] PC_RESET = 32'h0;
   localparam logic [31:0] PC_STEP  = 32'd4;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:2], 2'b00};
   endfunction
endpackage

// File: rtl/ifetch_fifo.sv
// Generic synchronous FIFO with synchronous clear; storage resets to RESET_VAL so
// the head reads a defined value straight out of reset.
module ifetch_fifo #(
   parameter int               WIDTH     = 32,
   parameter int               DEPTH     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clear,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   // explicit wrap keeps non-power-of-two depths correct
   function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= nxt(wr_ptr);
         end
         if (do_pop) rd_ptr <= nxt(rd_ptr);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end
endmodule

// File: rtl/ifetch_unit.sv
// Stage-1 fetch engine: issues imem requests from pc_in, buffers {pc, instr} for IF/ID,
// drops stale responses after a redirect. Optional IFETCH_MISALIGN_CHK_EN adds fetch_misalign.
module ifetch_unit
   import ifetch_pkg::*;
#(
   parameter int FIFO_DEPTH      = 2,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_in,
   output logic        pc_advance,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4,
   input  logic        id_ready
`ifdef IFETCH_MISALIGN_CHK_EN
   ,
   output logic        fetch_misalign
`endif
);
   localparam int OUT_W = $clog2(MAX_OUTSTANDING+1);
   localparam int CNT_W = $clog2(FIFO_DEPTH+1);

   logic [OUT_W-1:0]  outstanding, drop_cnt;
   logic [CNT_W-1:0]  fifo_count;
   logic              fire, credit_ok, keep_rsp, misalign;
   logic              pend_empty, pend_full, buf_empty, buf_full;
   logic [ADDR_W-1:0] pend_pc;
   fetch_entry_t      head, rsp_entry;

`ifdef IFETCH_MISALIGN_CHK_EN
   assign misalign  = (pc_in[1:0] != 2'b00);
   assign imem_addr = pc_in;

   always_ff @(posedge clk) begin
      if (reset || flush) fetch_misalign <= 1'b0;
      else if (misalign)  fetch_misalign <= 1'b1;
   end
`else
   assign misalign  = 1'b0;
   assign imem_addr = word_addr(pc_in);
`endif

   // every in-flight request owns a guaranteed slot in the fetch buffer
   assign credit_ok  = (32'(outstanding) + 32'(fifo_count) < 32'(FIFO_DEPTH)) &&
                       (32'(outstanding) < 32'(MAX_OUTSTANDING));
   assign imem_req   = !reset && !flush && credit_ok && !misalign;
   assign fire       = imem_req && imem_ready;
   assign pc_advance = !reset && (fire || flush);

   assign keep_rsp  = imem_rvalid && (drop_cnt == '0) && !flush;
   assign rsp_entry = '{pc: pend_pc, instr: imem_rdata};

   ifetch_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUTSTANDING), .RESET_VAL(PC_RESET)) u_pend (
      .clk(clk), .reset(reset), .clear(1'b0),
      .push(fire), .push_data(pc_in), .pop(imem_rvalid),
      .head(pend_pc), .empty(pend_empty), .full(pend_full), .count(outstanding)
   );

   ifetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH),
                 .RESET_VAL({PC_RESET, {INSTR_W{1'b0}}})) u_buf (
      .clk(clk), .reset(reset), .clear(flush),
      .push(keep_rsp), .push_data(rsp_entry), .pop(id_ready),
      .head(head), .empty(buf_empty), .full(buf_full), .count(fifo_count)
   );

   // a flush re-derives the drop count from what is still in flight, so repeated
   // flushes never count the same response twice
   always_ff @(posedge clk) begin
      if (reset)                              drop_cnt <= '0;
      else if (flush)                         drop_cnt <= outstanding - OUT_W'(imem_rvalid);
      else if (imem_rvalid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
   end

   assign if_valid    = !buf_empty;
   assign if_pc       = head.pc;
   assign if_instr    = head.instr;
   assign if_pc_plus4 = head.pc + PC_STEP;

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(keep_rsp && buf_full));
         assert (!(imem_rvalid && pend_empty));
         assert (!(fire && pend_full));
      end
   end
endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: bench-side PC register, in-order memory model
// and a delivery scoreboard derived from the credit/flush rules.
module tb_ifetch_unit;
   localparam int FD = 2;
   localparam int MO = 2;

   logic        clk = 1'b0;
   logic        reset, flush, imem_ready, imem_rvalid, id_ready;
   logic [31:0] pc_in, imem_rdata;
   logic        pc_advance, imem_req, if_valid;
   logic [31:0] imem_addr, if_instr, if_pc, if_pc_plus4;
`ifdef IFETCH_MISALIGN_CHK_EN
   logic        fetch_misalign;
`endif

   ifetch_unit #(.FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO)) dut (
      .clk(clk), .reset(reset), .pc_in(pc_in), .pc_advance(pc_advance), .flush(flush),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
      .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .id_ready(id_ready)
`ifdef IFETCH_MISALIGN_CHK_EN
      , .fetch_misalign(fetch_misalign)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      bit          stale;
   } req_t;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] pc;
   req_t        mq[$];
   logic [63:0] eq[$];
   logic [31:0] deliv[$];
   logic [31:0] deliv_p4[$];

   function automatic logic [31:0] instr_of(input logic [31:0] p);
      logic [31:0] w;
      w = {p[31:2], 2'b00};
      return (w * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   // One clock of stimulus plus scoreboard; entered and left just after a falling edge.
   task automatic run_cycle(input bit fl, input logic [31:0] tgt, input bit idr,
                            input bit rdy, input bit rv_en);
      bit   rv, exp_req, exp_fire, had_head;
      req_t r;
      flush      = fl;
      id_ready   = idr;
      imem_ready = rdy;
      pc_in      = pc;
      rv         = rv_en && (mq.size() > 0);
      imem_rvalid = rv;
      imem_rdata  = rv ? instr_of(mq[0].pc) : $urandom;
      #1;
      exp_req  = !fl && (mq.size() + eq.size() < FD) && (mq.size() < MO);
      exp_fire = exp_req && rdy;
      had_head = (eq.size() > 0);
      total++;
      if (imem_req !== exp_req) begin
         bad++; $display("FAIL imem_req: got %b want %b pc=%h", imem_req, exp_req, pc);
      end
      total++;
      if (pc_advance !== (exp_fire || fl)) begin
         bad++; $display("FAIL pc_advance: got %b want %b", pc_advance, exp_fire || fl);
      end
      total++;
      if (imem_addr !== {pc[31:2], 2'b00}) begin
         bad++; $display("FAIL imem_addr: got %h want %h", imem_addr, {pc[31:2], 2'b00});
      end
      total++;
      if (if_valid !== had_head) begin
         bad++; $display("FAIL if_valid: got %b want %b", if_valid, had_head);
      end
      if (had_head) begin
         total++;
         if ({if_pc, if_instr} !== eq[0]) begin
            bad++; $display("FAIL if_head: got %h/%h want %h/%h", if_pc, if_instr,
                            eq[0][63:32], eq[0][31:0]);
         end
         total++;
         if (if_pc_plus4 !== eq[0][63:32] + 32'd4) begin
            bad++; $display("FAIL if_pc_plus4: got %h want %h", if_pc_plus4, eq[0][63:32] + 32'd4);
         end
      end
      if (if_valid && idr) begin
         deliv.push_back(if_pc);
         deliv_p4.push_back(if_pc_plus4);
      end
      @(posedge clk);
      if (had_head && idr) void'(eq.pop_front());
      if (rv) begin
         r = mq.pop_front();
         if (!r.stale) eq.push_back({r.pc, instr_of(r.pc)});
      end
      if (fl) begin
         eq.delete();
         foreach (mq[i]) mq[i].stale = 1'b1;
      end
      if (exp_fire) mq.push_back('{pc: pc, stale: 1'b0});
      if (fl)            pc = tgt;
      else if (exp_fire) pc = pc + 32'd4;
      @(negedge clk);
   endtask

   // Memory shares the reset, so in-flight responses vanish with it.
   task automatic do_reset();
      reset = 1'b1; flush = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; id_ready = 1'b0;
      pc = 32'h0; pc_in = pc;
      @(posedge clk);
      mq.delete(); eq.delete(); deliv.delete(); deliv_p4.delete();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; imem_ready = 1'b1; imem_rvalid = 1'b0; id_ready = 1'b1;
      imem_rdata = 32'h0; pc = 32'h0; pc_in = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      total++; if (imem_req !== 1'b0)    begin bad++; $display("FAIL rst_imem_req: got %b want 0", imem_req); end
      total++; if (pc_advance !== 1'b0)  begin bad++; $display("FAIL rst_pc_advance: got %b want 0", pc_advance); end
      total++; if (if_valid !== 1'b0)    begin bad++; $display("FAIL rst_if_valid: got %b want 0", if_valid); end
      total++; if (if_instr !== 32'h0)   begin bad++; $display("FAIL rst_if_instr: got %h want 0", if_instr); end
      total++; if (if_pc !== 32'h0)      begin bad++; $display("FAIL rst_if_pc: got %h want 0", if_pc); end
      total++; if (if_pc_plus4 !== 32'h4) begin bad++; $display("FAIL rst_if_pc_plus4: got %h want 4", if_pc_plus4); end
      reset = 1'b0;
   endtask

   task automatic test_streaming();
      do_reset();
      repeat (14) run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      total++;
      if (deliv.size() < 3 || deliv[0] !== 32'h0 || deliv[1] !== 32'h4 || deliv[2] !== 32'h8) begin
         bad++; $display("FAIL stream_order: got %0d entries first %h want 0,4,8", deliv.size(),
                         deliv.size() > 0 ? deliv[0] : 32'hx);
      end
      total++;
      if (deliv_p4.size() < 3 || deliv_p4[0] !== 32'h4 || deliv_p4[2] !== 32'hC) begin
         bad++; $display("FAIL stream_plus4: got %0d entries want 4,8,12", deliv_p4.size());
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] pc_frozen;
      repeat (3) run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      repeat (6) run_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      pc_frozen = pc;
      #1;
      total++; if (imem_req !== 1'b0)   begin bad++; $display("FAIL stall_imem_req: got %b want 0", imem_req); end
      total++; if (pc_advance !== 1'b0) begin bad++; $display("FAIL stall_pc_advance: got %b want 0", pc_advance); end
      total++; if (if_valid !== 1'b1)   begin bad++; $display("FAIL stall_if_valid: got %b want 1", if_valid); end
      total++;
      if (imem_addr !== {pc_frozen[31:2], 2'b00}) begin
         bad++; $display("FAIL stall_addr: got %h want %h", imem_addr, {pc_frozen[31:2], 2'b00});
      end
      deliv.delete();
      repeat (12) run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      total++;
      if (deliv.size() < 2 || deliv[1] !== deliv[0] + 32'd4) begin
         bad++; $display("FAIL resume_order: got %0d entries", deliv.size());
      end
   endtask

   task automatic test_flush();
      do_reset();
      pc = 32'h10;
      run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      run_cycle(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
      total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL flush_if_valid: got %b want 0", if_valid); end
      deliv.delete();
      repeat (8) run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      total++;
      if (deliv.size() == 0 || deliv[0] !== 32'h100) begin
         bad++; $display("FAIL flush_first_pc: got %h want 00000100", deliv.size() > 0 ? deliv[0] : 32'hx);
      end
   endtask

   task automatic test_flush_rvalid();
      do_reset();
      pc = 32'h40;
      run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      run_cycle(1'b1, 32'h200, 1'b1, 1'b0, 1'b1);
      deliv.delete();
      repeat (8) run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      total++;
      if (deliv.size() == 0 || deliv[0] !== 32'h200) begin
         bad++; $display("FAIL flush_rv_first_pc: got %h want 00000200", deliv.size() > 0 ? deliv[0] : 32'hx);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      run_cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
      deliv.delete(); deliv_p4.delete();
      repeat (6) run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      total++;
      if (deliv.size() < 2 || deliv[0] !== 32'hFFFF_FFFC || deliv_p4[0] !== 32'h0 || deliv[1] !== 32'h0) begin
         bad++; $display("FAIL wrap_plus4: got %0d entries p4=%h want fffffffc->00000000", deliv.size(),
                         deliv_p4.size() > 0 ? deliv_p4[0] : 32'hx);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      run_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      run_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      run_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_if_valid: got %b want 1", if_valid); end
      do_reset();
      id_ready = 1'b1; imem_ready = 1'b0;
      #1;
      total++; if (if_valid !== 1'b0)      begin bad++; $display("FAIL mid_rst_if_valid: got %b want 0", if_valid); end
      total++; if (imem_req !== 1'b1)      begin bad++; $display("FAIL mid_rst_imem_req: got %b want 1", imem_req); end
      total++; if (imem_addr !== 32'h0)    begin bad++; $display("FAIL mid_rst_imem_addr: got %h want 0", imem_addr); end
      repeat (6) run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         run_cycle($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
      end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_flush_rvalid();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
